// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. It owns the fetch PC, issues one request at a
// time on an SRAM-like instruction port, and presents each fetched
// instruction to decode with a valid/allowin handshake. Exception, eret and
// branch redirects retarget the fetch PC. Any in-flight fetch that a redirect
// makes stale is dropped when its data comes back.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   inst_req        request to the instruction port (held until addr_ok)
//   inst_addr       request address (stable while inst_req=1)
//   inst_addr_ok    request accepted this cycle
//   inst_data_ok    read data returned this cycle
//   inst_rdata      returned instruction word
//   exc_valid       redirect to EXC_VEC (highest priority)
//   eret_valid      redirect to epc
//   epc             eret target
//   br_taken        redirect to br_target (lowest priority)
//   br_target       branch/jump target
//   id_allowin      decode accepts the presented instruction
//   if_valid        if_pc/if_inst valid toward decode
//   if_pc, if_inst  presented PC and instruction
//   fetch_pc        next-fetch PC register
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int                 WIDTH    = 32,
   parameter logic [WIDTH-1:0]   RESET_PC = 32'hbfc0_0000,
   parameter logic [WIDTH-1:0]   EXC_VEC  = 32'hbfc0_0380
) (
   input  logic             clk,
   input  logic             rst,
   output logic             inst_req,
   output logic [WIDTH-1:0] inst_addr,
   input  logic             inst_addr_ok,
   input  logic             inst_data_ok,
   input  logic [WIDTH-1:0] inst_rdata,
   input  logic             exc_valid,
   input  logic             eret_valid,
   input  logic [WIDTH-1:0] epc,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             id_allowin,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_inst,
   output logic [WIDTH-1:0] fetch_pc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(3'd4);

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] fetch_pc_r;
   logic [WIDTH-1:0] req_addr_r;
   logic             stale_r;
   logic [WIDTH-1:0] if_pc_r;
   logic [WIDTH-1:0] if_inst_r;

   logic             redirect_s;
   logic [WIDTH-1:0] target_s;
   logic             capture_s;
   logic             enter_req_s;

   // Redirect detection and priority select of the redirect target
   always_comb begin
      redirect_s = exc_valid | eret_valid | br_taken;
      if (exc_valid) begin
         target_s = EXC_VEC;
      end else if (eret_valid) begin
         target_s = epc;
      end else if (br_taken) begin
         target_s = br_target;
      end else begin
         target_s = fetch_pc_r;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            state_next_s = REQ;
         end
         REQ: begin
            if (inst_addr_ok) begin
               state_next_s = WAIT;
            end else begin
               state_next_s = REQ;
            end
         end
         WAIT: begin
            if (inst_data_ok) begin
               // Returned data is usable only when no redirect has touched it
               if (stale_r || redirect_s) begin
                  state_next_s = REQ;
               end else begin
                  state_next_s = VALID;
               end
            end else begin
               state_next_s = WAIT;
            end
         end
         VALID: begin
            if (redirect_s || id_allowin) begin
               state_next_s = REQ;
            end else begin
               state_next_s = VALID;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Output decode from the state register
   always_comb begin
      inst_req  = (state_r == REQ);
      inst_addr = req_addr_r;
      if_valid  = (state_r == VALID);
      if_pc     = if_pc_r;
      if_inst   = if_inst_r;
      fetch_pc  = fetch_pc_r;
   end

   // Capture strobe and REQ-entry strobe for the datapath
   always_comb begin
      capture_s   = (state_r == WAIT) && inst_data_ok && !stale_r && !redirect_s;
      enter_req_s = (state_r != REQ) && (state_next_s == REQ);
   end

   // Fetch PC, request address, stale flag and presented instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r <= RESET_PC;
         req_addr_r <= RESET_PC;
         stale_r    <= 1'b0;
         if_pc_r    <= RESET_PC;
         if_inst_r  <= '0;
      end else begin
         if (redirect_s) begin
            fetch_pc_r <= target_s;
         end else if (capture_s) begin
            fetch_pc_r <= req_addr_r + PC_STEP;
         end else begin
            fetch_pc_r <= fetch_pc_r;
         end

         // A new request always starts from the up-to-date fetch PC,
         // which on a redirect cycle is the redirect target itself.
         if (enter_req_s) begin
            req_addr_r <= redirect_s ? target_s : fetch_pc_r;
         end else begin
            req_addr_r <= req_addr_r;
         end

         // Stale marks an accepted-or-pending request whose data must be
         // dropped; it is cleared when that data finally returns.
         case (state_r)
            REQ: begin
               if (redirect_s) begin
                  stale_r <= 1'b1;
               end else begin
                  stale_r <= stale_r;
               end
            end
            WAIT: begin
               if (inst_data_ok) begin
                  stale_r <= 1'b0;
               end else if (redirect_s) begin
                  stale_r <= 1'b1;
               end else begin
                  stale_r <= stale_r;
               end
            end
            default: begin
               stale_r <= stale_r;
            end
         endcase

         if (capture_s) begin
            if_pc_r   <= req_addr_r;
            if_inst_r <= inst_rdata;
         end else begin
            if_pc_r   <= if_pc_r;
            if_inst_r <= if_inst_r;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed, table-driven bench for fetch_ctrl. Each table record holds the
// inputs applied for one clock and the outputs expected just after that
// clock edge. Hand-written sequences follow for PC wrap, a redirect in the
// same cycle as data_ok, and a redirect in IDLE.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam logic [31:0] A   = 32'hbfc0_0000;
   localparam logic [31:0] A4  = 32'hbfc0_0004;
   localparam logic [31:0] EV  = 32'hbfc0_0380;
   localparam logic [31:0] B   = 32'h8000_1000;
   localparam logic [31:0] B4  = 32'h8000_1004;
   localparam logic [31:0] E   = 32'h8000_0200;
   localparam logic [31:0] E4  = 32'h8000_0204;
   localparam logic [31:0] I1  = 32'h2401_0001;
   localparam logic [31:0] I2  = 32'h3c1d_0000;
   localparam logic [31:0] I3  = 32'h8c88_0000;
   localparam logic [31:0] I4  = 32'h0000_0008;
   localparam int          NV  = 38;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        exc_valid;
   logic        eret_valid;
   logic [31:0] epc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        id_allowin;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] fetch_pc;

   int compared;
   int mismatched;

   typedef struct {
      logic [31:0] rst, aok, dok, rdata, exc, eret, epc, br, brt, allow;
      logic [31:0] e_req, e_addr, e_val, e_pc, e_inst, e_fpc;
   } vec_t;

   vec_t tbl [NV];

   fetch_ctrl #(
      .WIDTH    (32),
      .RESET_PC (32'hbfc0_0000),
      .EXC_VEC  (32'hbfc0_0380)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .exc_valid    (exc_valid),
      .eret_valid   (eret_valid),
      .epc          (epc),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .id_allowin   (id_allowin),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .fetch_pc     (fetch_pc)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clr_inputs();
      rst          = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0;
      exc_valid    = 1'b0;
      eret_valid   = 1'b0;
      epc          = 32'h0;
      br_taken     = 1'b0;
      br_target    = 32'h0;
      id_allowin   = 1'b0;
   endtask

   // One clock; outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      clr_inputs();

      //         rst aok dok rdata          exc eret epc br brt allow | req addr val pc inst fpc
      tbl[0]  = '{1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, A,  0, A, 0,  A };  // reset
      tbl[1]  = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  1, A,  0, A, 0,  A };  // IDLE->REQ
      tbl[2]  = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, A,  0, A, 0,  A };  // addr_ok
      tbl[3]  = '{0, 0, 1, I1,             0, 0, 0, 0, 0, 0,  0, A,  1, A, I1, A4};  // capture
      tbl[4]  = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1,  1, A4, 0, A, I1, A4};  // allowin
      tbl[5]  = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, A4, 0, A, I1, A4};
      tbl[6]  = '{0, 0, 0, 32'h0,          0, 0, 0, 1, B, 0,  0, A4, 0, A, I1, B };  // br in WAIT
      tbl[7]  = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, A4, 0, A, I1, B };
      tbl[8]  = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, A4, 0, A, I1, B };
      tbl[9]  = '{0, 0, 1, 32'hdeadbeef,   0, 0, 0, 0, 0, 0,  1, B,  0, A, I1, B };  // stale drop
      tbl[10] = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B,  0, A, I1, B };
      tbl[11] = '{0, 0, 1, I2,             0, 0, 0, 0, 0, 0,  0, B,  1, B, I2, B4};
      tbl[12] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B,  1, B, I2, B4};  // hold x5
      tbl[13] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B,  1, B, I2, B4};
      tbl[14] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B,  1, B, I2, B4};
      tbl[15] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B,  1, B, I2, B4};
      tbl[16] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B,  1, B, I2, B4};
      tbl[17] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1,  1, B4, 0, B, I2, B4};
      tbl[18] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  1, B4, 0, B, I2, B4};  // addr_ok late
      tbl[19] = '{0, 0, 0, 32'h0,          0, 1, E, 0, 0, 0,  1, B4, 0, B, I2, E };  // eret in REQ
      tbl[20] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  1, B4, 0, B, I2, E };
      tbl[21] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  1, B4, 0, B, I2, E };
      tbl[22] = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B4, 0, B, I2, E };
      tbl[23] = '{0, 0, 1, 32'h11111111,   0, 0, 0, 0, 0, 0,  1, E,  0, B, I2, E };
      tbl[24] = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, E,  0, B, I2, E };
      tbl[25] = '{0, 0, 1, I3,             0, 0, 0, 0, 0, 0,  0, E,  1, E, I3, E4};
      tbl[26] = '{0, 0, 0, 32'h0,          1, 0, 0, 1, B, 0,  1, EV, 0, E, I3, EV};  // exc+br in VALID
      tbl[27] = '{0, 0, 0, 32'h0,          0, 1, E, 1, B, 0,  1, EV, 0, E, I3, E };  // eret beats br
      tbl[28] = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, EV, 0, E, I3, E };
      tbl[29] = '{0, 0, 1, 32'h22222222,   0, 0, 0, 0, 0, 0,  1, E,  0, E, I3, E };
      tbl[30] = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, E,  0, E, I3, E };
      tbl[31] = '{0, 0, 1, I4,             0, 0, 0, 0, 0, 0,  0, E,  1, E, I4, E4};
      tbl[32] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1,  1, E4, 0, E, I4, E4};
      tbl[33] = '{0, 1, 0, 32'h0,          0, 0, 0, 1, B, 0,  0, E4, 0, E, I4, B };  // br with addr_ok
      tbl[34] = '{0, 0, 1, 32'h33333333,   0, 0, 0, 0, 0, 0,  1, B,  0, E, I4, B };
      tbl[35] = '{0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, B,  0, E, I4, B };
      tbl[36] = '{1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  0, A,  0, A, 0,  A };  // reset in WAIT
      tbl[37] = '{0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0,  1, A,  0, A, 0,  A };

      for (int i = 0; i < NV; i++) begin
         rst          = tbl[i].rst[0];
         inst_addr_ok = tbl[i].aok[0];
         inst_data_ok = tbl[i].dok[0];
         inst_rdata   = tbl[i].rdata;
         exc_valid    = tbl[i].exc[0];
         eret_valid   = tbl[i].eret[0];
         epc          = tbl[i].epc;
         br_taken     = tbl[i].br[0];
         br_target    = tbl[i].brt;
         id_allowin   = tbl[i].allow[0];
         tick();
         chk($sformatf("v%0d.inst_req", i),  {31'd0, inst_req}, tbl[i].e_req);
         chk($sformatf("v%0d.inst_addr", i), inst_addr,         tbl[i].e_addr);
         chk($sformatf("v%0d.if_valid", i),  {31'd0, if_valid}, tbl[i].e_val);
         chk($sformatf("v%0d.if_pc", i),     if_pc,             tbl[i].e_pc);
         chk($sformatf("v%0d.if_inst", i),   if_inst,           tbl[i].e_inst);
         chk($sformatf("v%0d.fetch_pc", i),  fetch_pc,          tbl[i].e_fpc);
      end

      // PC wrap: capture at 0xfffffffc makes the next fetch PC zero
      clr_inputs();
      br_taken = 1'b1; br_target = 32'hffff_fffc;
      tick();
      chk("wrap.redir_fpc", fetch_pc, 32'hffff_fffc);
      chk("wrap.req_hold",  inst_addr, A);
      clr_inputs(); inst_addr_ok = 1'b1; tick();
      clr_inputs(); inst_data_ok = 1'b1; inst_rdata = 32'hdead_0000; tick();
      chk("wrap.req_addr", inst_addr, 32'hffff_fffc);
      chk("wrap.stale_valid", {31'd0, if_valid}, 32'd0);
      clr_inputs(); inst_addr_ok = 1'b1; tick();
      clr_inputs(); inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678; tick();
      chk("wrap.if_valid", {31'd0, if_valid}, 32'd1);
      chk("wrap.if_pc",    if_pc,    32'hffff_fffc);
      chk("wrap.fetch_pc", fetch_pc, 32'h0000_0000);
      clr_inputs(); id_allowin = 1'b1; tick();
      chk("wrap.next_addr", inst_addr, 32'h0000_0000);

      // Redirect in the same cycle as data_ok: data dropped, target fetched
      clr_inputs(); inst_addr_ok = 1'b1; tick();
      clr_inputs(); inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555;
      br_taken = 1'b1; br_target = 32'h8000_3000; tick();
      chk("dokredir.if_valid", {31'd0, if_valid}, 32'd0);
      chk("dokredir.inst_req", {31'd0, inst_req}, 32'd1);
      chk("dokredir.addr",     inst_addr, 32'h8000_3000);
      chk("dokredir.if_inst",  if_inst,   32'h1234_5678);
      chk("dokredir.fetch_pc", fetch_pc,  32'h8000_3000);

      // Redirect during IDLE: the first request uses the target
      clr_inputs(); rst = 1'b1; tick();
      chk("idle.inst_req", {31'd0, inst_req}, 32'd0);
      clr_inputs(); exc_valid = 1'b1; tick();
      chk("idle.inst_req2", {31'd0, inst_req}, 32'd1);
      chk("idle.addr",      inst_addr, EV);
      chk("idle.fetch_pc",  fetch_pc,  EV);
      clr_inputs(); tick();
      chk("idle.addr_hold", inst_addr, EV);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the fetch PC register and drives an SRAM-like instruction port (req / addr_ok / data_ok).
- Presents one fetched instruction at a time to the decode stage with a valid/allowin handshake.
- Applies redirects from exception, eret and branch, and discards any in-flight fetch made stale by a redirect.
- Sits between the instruction bus interface and the IF/ID boundary of the MIPS core.

Parameters:
- WIDTH, 32, address/data width.
- RESET_PC, 32'hbfc0_0000, fetch address after reset.
- EXC_VEC, 32'hbfc0_0380, exception entry address.

Ports:
- clk  input  1  core clock, all state changes on posedge
- rst  input  1  synchronous active-high reset
- inst_req  output  1  fetch request to instruction port
- inst_addr  output  WIDTH  fetch address; equals req_addr, stable while inst_req=1
- inst_addr_ok  input  1  request accepted this cycle
- inst_data_ok  input  1  read data returned this cycle
- inst_rdata  input  WIDTH  returned instruction word
- exc_valid  input  1  exception redirect to EXC_VEC
- eret_valid  input  1  eret redirect to epc
- epc  input  WIDTH  eret target
- br_taken  input  1  branch/jump redirect
- br_target  input  WIDTH  branch target
- id_allowin  input  1  decode accepts instruction this cycle
- if_valid  output  1  if_inst/if_pc valid toward decode
- if_pc  output  WIDTH  PC of presented instruction
- if_inst  output  WIDTH  presented instruction
- fetch_pc  output  WIDTH  current next-fetch PC register

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, stale=0, inst_req=0, if_valid=0, if_pc=RESET_PC, if_inst=0. Reset overrides every other input, including mid-transaction; no pending data_ok is tracked across reset.
- States: IDLE, REQ, WAIT, VALID.
- IDLE: the cycle after reset release -> REQ, req_addr<=fetch_pc.
- REQ: inst_req=1, inst_addr=req_addr. inst_addr_ok -> WAIT. req is never withdrawn and the address never changes before addr_ok.
- WAIT: inst_req=0. Waits for inst_data_ok.
  - If data_ok and stale=0 and no redirect this cycle: if_inst<=inst_rdata, if_pc<=req_addr, fetch_pc<=req_addr+4 (mod 2^WIDTH, wraps), go VALID.
  - If data_ok and (stale=1 or redirect this cycle): discard data, stale<=0, go REQ with req_addr<=updated fetch_pc.
- VALID: if_valid=1.
  - id_allowin=1 and no redirect: go REQ, req_addr<=fetch_pc.
  - Redirect (regardless of id_allowin): drop the held instruction, if_valid=0 next cycle, go REQ with req_addr<=target.
  - Otherwise hold all outputs unchanged.
- Redirect priority: exc_valid > eret_valid > br_taken. target = EXC_VEC, epc or br_target respectively.
  - Any redirect in any non-IDLE state: fetch_pc<=target next cycle.
  - Redirect in REQ: set stale<=1 (also in the same cycle as addr_ok). The REQ address is unchanged.
  - Redirect in WAIT without data_ok: stale<=1.
  - Redirect in IDLE: fetch_pc<=target, and the first request uses target.
- Redirect inputs are single-cycle pulses and are not buffered.
- data_ok never arrives in the same cycle as its own addr_ok; at most one request is outstanding.
- Minimum throughput: one instruction per 3 cycles (REQ, WAIT, VALID) with a 1-cycle-latency port.
- if_pc/if_inst change only when entering VALID; they are don't-care when if_valid=0 but keep their last value.
- fetch_pc changes only on redirect, non-stale capture, or reset.

Test Plan:
- Reset then zero-wait port (addr_ok in REQ, data_ok next cycle, rdata=0x24010001) -> inst_addr=0xbfc00000 on the 2nd cycle after reset; if_valid=1 with if_pc=0xbfc00000 and if_inst=0x24010001; the next request uses 0xbfc00004.
- br_taken=1, br_target=0x80001000 while in WAIT; data_ok arrives 3 cycles later -> data discarded, if_valid stays 0, next inst_addr=0x80001000.
- exc_valid and br_taken in the same cycle during VALID -> held instruction dropped, next inst_addr=0xbfc00380, fetch_pc=0xbfc00380.
- id_allowin=0 for 5 cycles in VALID -> if_valid, if_pc and if_inst stable; inst_req=0 throughout; REQ follows in the cycle after allowin=1.
- addr_ok delayed 4 cycles -> inst_req and inst_addr held constant for all 4 cycles. With eret_valid (epc=0x80000200) pulsed during that window, the returned data is discarded and the next fetch is at 0x80000200.
- rst asserted in WAIT -> next cycle state IDLE, inst_req=0, if_valid=0, fetch_pc=0xbfc00000.
